// File: rtl/mdu_pipe.sv
// Multiply/divide unit: pipelined multiplier, iterative radix-2 divider and a
// shared result FIFO drained onto the CDB. Dispatch credits guarantee the FIFO never overflows.
module mdu_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 6,
  parameter int MUL_STAGES = 2,
  parameter int OUT_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_rdy,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_gnt
);

  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int STEP_W = $clog2(XLEN);
  localparam int PW     = 2 * XLEN;
  localparam int LAST   = MUL_STAGES - 1;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  div_state_t div_state, div_next;

  logic             accept, is_div, pop;
  logic [CNT_W-1:0] occ;

  assign is_div = in_op[2];
  assign accept = in_valid && in_rdy;
  assign pop    = out_valid && out_gnt;

  always_comb begin
    in_rdy = !rst && !flush && (occ < CNT_W'(OUT_DEPTH)) &&
             (!is_div || div_state == DIV_IDLE);
  end

  // Every op holds one credit from accept until it leaves the FIFO head.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst || flush) occ <= '0;
    else              occ <= occ + CNT_W'(accept) - CNT_W'(pop);
  end

  // ---------------- multiplier ----------------
  logic                  mul_a_sgn, mul_b_sgn;
  logic signed [XLEN:0]  a_ext, b_ext;
  logic [PW-1:0]         prod;
  logic [MUL_STAGES-1:0] m_vld;
  logic                  m_lo   [MUL_STAGES];
  logic [TAG_W-1:0]      m_tag  [MUL_STAGES];
  logic [PW-1:0]         m_prod [MUL_STAGES];
  logic                  mul_wr;
  logic [XLEN-1:0]       mul_res;

  assign mul_a_sgn = (in_op[1:0] != 2'b11);
  assign mul_b_sgn = !in_op[1];
  assign a_ext     = {mul_a_sgn & in_a[XLEN-1], in_a};
  assign b_ext     = {mul_b_sgn & in_b[XLEN-1], in_b};
  // Low 2*XLEN bits of the sign-extended product are exact for all four ops.
  assign prod      = PW'(a_ext) * PW'(b_ext);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_vld <= '0;
    end else begin
      m_vld[0] <= accept && !is_div;
      for (int i = 1; i < MUL_STAGES; i++) m_vld[i] <= m_vld[i-1];
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    m_prod[0] <= prod;
    m_lo[0]   <= (in_op[1:0] == 2'b00);
    m_tag[0]  <= in_tag;
    for (int i = 1; i < MUL_STAGES; i++) begin
      m_prod[i] <= m_prod[i-1];
      m_lo[i]   <= m_lo[i-1];
      m_tag[i]  <= m_tag[i-1];
    end
  end

  assign mul_wr  = m_vld[LAST];
  assign mul_res = m_lo[LAST] ? m_prod[LAST][XLEN-1:0] : m_prod[LAST][PW-1:XLEN];

  // ---------------- divider ----------------
  logic              div_sgn, a_neg, b_neg, div_wr;
  logic [XLEN-1:0]   a_mag, b_mag, div_res;
  logic [XLEN-1:0]   d_rem, d_quo, d_div, d_a;
  logic [STEP_W-1:0] d_cnt;
  logic              d_first, d_zero, d_ovf, d_neg_q, d_neg_r, d_rem_op;
  logic [TAG_W-1:0]  d_tag;
  logic [XLEN:0]     r_sh, diff;
  logic              ge;

  assign div_sgn = !in_op[0];
  assign a_neg   = div_sgn & in_a[XLEN-1];
  assign b_neg   = div_sgn & in_b[XLEN-1];
  assign a_mag   = a_neg ? -in_a : in_a;
  assign b_mag   = b_neg ? -in_b : in_b;

  assign r_sh = {d_rem, d_quo[XLEN-1]};
  assign diff = r_sh - {1'b0, d_div};
  assign ge   = !diff[XLEN];

  always_ff @(posedge clk) begin
    if (rst || flush) div_state <= DIV_IDLE;
    else              div_state <= div_next;
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (accept && is_div) div_next = DIV_BUSY;
      DIV_BUSY: if ((d_first && (d_zero || d_ovf)) || d_cnt == '0) div_next = DIV_DONE;
      DIV_DONE: if (!mul_wr) div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (div_state == DIV_IDLE && accept && is_div) begin
      d_rem    <= '0;
      d_quo    <= a_mag;
      d_div    <= b_mag;
      d_a      <= in_a;
      d_neg_q  <= a_neg ^ b_neg;
      d_neg_r  <= a_neg;
      d_rem_op <= in_op[1];
      d_tag    <= in_tag;
      d_zero   <= (in_b == '0);
      d_ovf    <= div_sgn && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      d_cnt    <= STEP_W'(XLEN - 1);
      d_first  <= 1'b1;
    end else if (div_state == DIV_BUSY) begin
      d_first <= 1'b0;
      if (d_first && d_zero) begin
        d_quo   <= '1;
        d_rem   <= d_a;
        d_neg_q <= 1'b0;
        d_neg_r <= 1'b0;
      end else if (d_first && d_ovf) begin
        d_quo   <= d_a;
        d_rem   <= '0;
        d_neg_q <= 1'b0;
        d_neg_r <= 1'b0;
      end else begin
        d_rem <= ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
        d_quo <= {d_quo[XLEN-2:0], ge};
        d_cnt <= d_cnt - STEP_W'(1);
      end
    end
  end

  assign div_res = d_rem_op ? (d_neg_r ? -d_rem : d_rem) : (d_neg_q ? -d_quo : d_quo);
  // The multiplier has no stall path, so it owns the write port on a collision.
  assign div_wr  = (div_state == DIV_DONE) && !mul_wr;

  // ---------------- output FIFO ----------------
  logic                 fifo_wr;
  logic [XLEN-1:0]      w_data;
  logic [TAG_W-1:0]     w_tag;
  logic [XLEN-1:0]      f_data [OUT_DEPTH];
  logic [TAG_W-1:0]     f_tag  [OUT_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     f_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_wr = mul_wr || div_wr;
  assign w_data  = mul_wr ? mul_res : div_res;
  assign w_tag   = mul_wr ? m_tag[LAST] : d_tag;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_cnt  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      f_cnt <= f_cnt + CNT_W'(fifo_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      f_data[wr_ptr] <= w_data;
      f_tag[wr_ptr]  <= w_tag;
    end
  end

  assign out_valid = (f_cnt != '0);
  assign out_data  = out_valid ? f_data[rd_ptr] : '0;
  assign out_tag   = out_valid ? f_tag[rd_ptr]  : '0;

endmodule

// File: tb/tb_mdu_pipe.sv
// Scoreboard bench for mdu_pipe: directed timing cases plus randomized ops,
// checked against an arithmetic reference model keyed by destination tag.
module tb_mdu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_rdy, out_valid, out_gnt;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_data;
  logic [5:0]  in_tag, out_tag;

  mdu_pipe #(.XLEN(32), .TAG_W(6), .MUL_STAGES(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_rdy(in_rdy),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_gnt(out_gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    bit          is_mul;
    int          issue_cyc;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [5:0] next_tag = 6'd0;
  bit         rand_gnt = 1'b0;
  bit         gnt_fix  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int              ia, ib;
    longint          p;
    longint unsigned up;
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = longint'(ia) * longint'(ib); return p[31:0]; end
      3'd1: begin p = longint'(ia) * longint'(ib); return p[63:32]; end
      3'd2: begin p = longint'(ia) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Grant is applied mid-cycle so stimulus written just after the edge takes effect the same cycle.
  initial begin
    out_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      out_gnt = rand_gnt ? ($urandom_range(0, 1) == 1) : gnt_fix;
    end
  end

  // Monitor: every popped result must match an outstanding tag; muls leave in issue order.
  always @(negedge clk) begin
    int idx;
    bit older;
    if (!rst && out_valid === 1'b1 && out_gnt) begin
      idx = -1;
      older = 1'b0;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].tag == out_tag) begin
          idx = i;
          break;
        end
      end
      check($sformatf("pop_tag_known tag=%0d", out_tag), idx >= 0, 1);
      if (idx >= 0) begin
        check($sformatf("result tag=%0d", out_tag), out_data, sb[idx].data);
        if (sb[idx].is_mul) begin
          for (int i = 0; i < idx; i++) if (sb[i].is_mul) older = 1'b1;
          check($sformatf("mul_order tag=%0d", out_tag), older, 0);
        end
        if (sb[idx].lat != 0)
          check($sformatf("latency tag=%0d", out_tag), cyc - sb[idx].issue_cyc, sb[idx].lat);
        sb.delete(idx);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  // All stimulus tasks start and end one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit must_now, output int t_acc);
    int   waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = next_tag;
    #1;
    if (must_now) check($sformatf("in_rdy op=%0d", op), in_rdy, 1);
    while (in_rdy !== 1'b1 && waited < 300) begin
      @(posedge clk);
      #2;
      waited++;
    end
    t_acc = cyc;
    if (in_rdy !== 1'b1) begin
      check("issue_timeout", waited, 0);
    end else begin
      e.tag       = next_tag;
      e.data      = model(op, a, b);
      e.is_mul    = !op[2];
      e.issue_cyc = cyc;
      e.lat       = lat;
      sb.push_back(e);
      next_tag++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int n);
    int k;
    k = 0;
    while (sb.size() != 0 && k < n) begin
      idle(1);
      k++;
    end
    check(name, sb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int          t, t0;
    logic [5:0]  first_tag;
    logic [31:0] first_val;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst in_rdy", in_rdy, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_tag", out_tag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;

    // Back-to-back multiplies
    issue(3'd0, 32'd5, 32'd7, 3, 1, t);
    issue(3'd0, -32'sd3, 32'd4, 3, 1, t);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, t);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 3, 1, t);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, t);
    wait_drain("drain_mul", 20);

    // Normal divides
    issue(3'd4, -32'sd7, 32'd2, 34, 1, t);
    issue(3'd6, -32'sd7, 32'd2, 34, 0, t);
    issue(3'd5, 32'd100, 32'd7, 34, 0, t);
    issue(3'd7, 32'd100, 32'd7, 34, 0, t);
    issue(3'd4, 32'd7, -32'sd2, 34, 0, t);
    wait_drain("drain_div", 80);

    // Special-case divides
    issue(3'd4, 32'd5, 32'd0, 3, 1, t);
    issue(3'd6, 32'd9, 32'd0, 3, 0, t);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, t);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, t);
    issue(3'd5, 32'd17, 32'd0, 3, 0, t);
    issue(3'd7, 32'd17, 32'd0, 3, 0, t);
    wait_drain("drain_special", 20);

    // Back-pressure: no grant, fill credits, head must hold
    gnt_fix = 1'b0;
    idle(1);
    first_tag = next_tag;
    first_val = model(3'd0, 32'd11, 32'd13);
    issue(3'd0, 32'd11, 32'd13, 0, 1, t);
    for (int i = 0; i < 3; i++) issue(3'd0, 32'd100 + i, 32'd3 + i, 0, 1, t);
    idle(1);
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd2; in_b = 32'd2; in_tag = next_tag;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp in_rdy", in_rdy, 0);
      check("bp out_valid", out_valid, 1);
      check("bp out_data", out_data, first_val);
      check("bp out_tag", out_tag, first_tag);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    gnt_fix = 1'b1;
    issue(3'd0, 32'd2, 32'd2, 0, 0, t);
    wait_drain("drain_bp", 30);

    // Mixing: muls issue around a busy divider, second div is held off
    issue(3'd4, 32'd1000, 32'd3, 34, 1, t);
    for (int i = 0; i < 4; i++) begin
      issue(3'd0, 32'd3 * i, 32'd5, 3, 1, t);
      in_valid = 1'b1; in_op = 3'd5; in_a = 32'd9; in_b = 32'd4; in_tag = next_tag;
      #1;
      check("mix div in_rdy", in_rdy, 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    wait_drain("drain_mix", 60);

    // Collision: mul leaves the pipe in the divider's DONE cycle
    issue(3'd5, 32'd1000, 32'd3, 35, 1, t0);
    while (cyc < t0 + 31) idle(1);
    issue(3'd0, 32'd6, 32'd7, 3, 1, t);
    wait_drain("drain_collide", 60);

    // Flush with divider busy, muls in the pipe and a buffered result
    gnt_fix = 1'b0;
    idle(1);
    issue(3'd5, 32'd100, 32'd7, 0, 1, t);
    issue(3'd0, 32'd21, 32'd2, 0, 1, t);
    idle(3);
    issue(3'd0, 32'd8, 32'd8, 0, 1, t);
    issue(3'd0, 32'd9, 32'd9, 0, 1, t);
    check("pre_flush out_valid", out_valid, 1);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 32'd4; in_b = 32'd4; in_tag = next_tag;
    #1;
    check("flush in_rdy", in_rdy, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    gnt_fix = 1'b1;
    #1;
    check("post_flush out_valid", out_valid, 0);
    check("post_flush in_rdy", in_rdy, 1);
    @(posedge clk);
    #1;
    issue(3'd0, 32'd2, 32'd3, 3, 1, t);
    idle(40);
    check("post_flush scoreboard", sb.size(), 0);

    // Randomized mix with random grant
    rand_gnt = 1'b1;
    for (int i = 0; i < 120; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 0, 0, t);
      idle($urandom_range(0, 1));
    end
    rand_gnt = 1'b0;
    gnt_fix  = 1'b1;
    wait_drain("drain_random", 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
